// File: rtl/tc_host_pkg.sv
// Shared types and constants for the tc host: FSM states, tc register map,
// interrupt flag bit positions and the vector codes handed to the CPU.
package tc_host_pkg;

  // tc register map
  localparam logic [7:0] ADDR_TCCRA = 8'h24;
  localparam logic [7:0] ADDR_TCCRB = 8'h25;
  localparam logic [7:0] ADDR_TCNT  = 8'h26;
  localparam logic [7:0] ADDR_OCRA  = 8'h27;
  localparam logic [7:0] ADDR_OCRB  = 8'h28;
  localparam logic [7:0] ADDR_TIFR  = 8'h15;
  localparam logic [7:0] ADDR_TIMSK = 8'h6e;

  // Interrupt flag layout inside TIFR/TIMSK
  localparam int unsigned NUM_FLAGS = 3;
  localparam int unsigned TOV_BIT   = 0;
  localparam int unsigned OCFA_BIT  = 1;
  localparam int unsigned OCFB_BIT  = 2;

  // Vector codes presented on isr_vector
  localparam logic [1:0] VEC_OCFA = 2'd1;
  localparam logic [1:0] VEC_OCFB = 2'd2;
  localparam logic [1:0] VEC_TOV  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    C_WR,
    C_RD,
    C_RDC,
    I_RDF,
    I_RDFC,
    I_RDM,
    I_RDMC,
    I_CLR,
    I_ISR,
    I_EXEC
  } state_t;

endpackage

// File: rtl/tc_irq_prio.sv
// Fixed-priority select over pending interrupt flags (OCFA > OCFB > TOV).
// Produces the one-hot write-1-to-clear mask for the winner, its vector
// code, and a flag when nothing is pending.
module tc_irq_prio
  import tc_host_pkg::*;
#(
  parameter int unsigned FLAG_W = NUM_FLAGS
) (
  input  logic [FLAG_W-1:0] pending,
  output logic [FLAG_W-1:0] clr_mask,
  output logic [1:0]        vector,
  output logic              none
);

  // Pick the highest-priority pending flag
  always_comb begin
    clr_mask = '0;
    vector   = 2'd0;
    none     = 1'b0;
    if (pending[OCFA_BIT]) begin
      clr_mask[OCFA_BIT] = 1'b1;
      vector             = VEC_OCFA;
    end else if (pending[OCFB_BIT]) begin
      clr_mask[OCFB_BIT] = 1'b1;
      vector             = VEC_OCFB;
    end else if (pending[TOV_BIT]) begin
      clr_mask[TOV_BIT]  = 1'b1;
      vector             = VEC_TOV;
    end else begin
      none               = 1'b1;
    end
  end

endmodule

// File: rtl/tc_host.sv
// Host-side initiator for the tc block. Turns single CPU register commands
// into tc bus cycles and services tc interrupts on its own: read TIFR and
// TIMSK, clear the winning flag, hand the vector to the CPU, then complete
// the interrupt_executed handshake.
//
// Handshakes: a command transfers in a cycle where cmd_valid and cmd_ready
// are both high; cmd_write/cmd_addr/cmd_wdata must be stable while cmd_valid
// is high. rsp_valid and isr_valid are single-cycle pulses with no
// back-pressure. isr_done is only looked at while a vector is outstanding.
module tc_host
  import tc_host_pkg::*;
#(
  parameter logic [7:0]  TIFR_ADDR  = ADDR_TIFR,
  parameter logic [7:0]  TIMSK_ADDR = ADDR_TIMSK,
  parameter int unsigned FLAG_W     = NUM_FLAGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        sreg_i,
  output logic        isr_valid,
  output logic [1:0]  isr_vector,
  input  logic        isr_done,
  output logic        write,
  output logic        read,
  output logic [7:0]  addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        interrupt_request,
  output logic        interrupt_executed,
  output logic        status_reg_interrupt_enable,
  output logic [15:0] irq_count,
  output logic [7:0]  spurious_count
);

  state_t              state;
  state_t              nxt;
  logic [7:0]          addr_q;
  logic [7:0]          wdata_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [FLAG_W-1:0]   mask_q;
  logic [FLAG_W-1:0]   pending;
  logic [FLAG_W-1:0]   clr_mask;
  logic [1:0]          win_vector;
  logic                none;
  logic                irq_take;

  // interrupt_executed is only ever high in I_EXEC, so it is implicitly low here
  assign irq_take = (state == IDLE) && interrupt_request && status_reg_interrupt_enable;
  assign pending  = flags_q & mask_q;

  tc_irq_prio #(.FLAG_W(FLAG_W)) u_prio (
    .pending  (pending),
    .clr_mask (clr_mask),
    .vector   (win_vector),
    .none     (none)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; the interrupt path wins over a simultaneous command
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (irq_take)       nxt = I_RDF;
        else if (cmd_valid) nxt = cmd_write ? C_WR : C_RD;
      end
      C_WR:    nxt = IDLE;
      C_RD:    nxt = C_RDC;
      C_RDC:   nxt = IDLE;
      I_RDF:   nxt = I_RDFC;
      I_RDFC:  nxt = I_RDM;
      I_RDM:   nxt = I_RDMC;
      I_RDMC:  nxt = I_CLR;
      I_CLR:   nxt = none ? I_EXEC : I_ISR;
      I_ISR:   if (isr_done) nxt = I_EXEC;
      I_EXEC:  if (!interrupt_request) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus strobes, command acceptance and handshake level decoded from state
  always_comb begin
    write              = 1'b0;
    read               = 1'b0;
    addr               = 8'h00;
    wdata              = 8'h00;
    cmd_ready          = 1'b0;
    interrupt_executed = 1'b0;
    case (state)
      IDLE:          cmd_ready = cmd_valid && !irq_take;
      C_WR: begin
        write = 1'b1;
        addr  = addr_q;
        wdata = wdata_q;
      end
      C_RD, C_RDC: begin
        read  = 1'b1;
        addr  = addr_q;
      end
      I_RDF, I_RDFC: begin
        read  = 1'b1;
        addr  = TIFR_ADDR;
      end
      I_RDM, I_RDMC: begin
        read  = 1'b1;
        addr  = TIMSK_ADDR;
      end
      I_CLR: begin
        if (!none) begin
          write = 1'b1;
          addr  = TIFR_ADDR;
          wdata = {{(8 - FLAG_W){1'b0}}, clr_mask};
        end
      end
      I_EXEC:        interrupt_executed = 1'b1;
      default: ;
    endcase
  end

  // Datapath: command latch, read capture, flag/mask capture, pulses, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q                      <= 8'h00;
      wdata_q                     <= 8'h00;
      flags_q                     <= '0;
      mask_q                      <= '0;
      rsp_valid                   <= 1'b0;
      rsp_rdata                   <= 8'h00;
      isr_valid                   <= 1'b0;
      isr_vector                  <= 2'd0;
      irq_count                   <= 16'h0000;
      spurious_count              <= 8'h00;
      status_reg_interrupt_enable <= 1'b0;
    end else begin
      rsp_valid <= (state == C_RDC);
      isr_valid <= (state == I_CLR) && !none;
      if (cmd_ready) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state == C_RDC)  rsp_rdata <= rdata;
      if (state == I_RDFC) flags_q   <= rdata[FLAG_W-1:0];
      if (state == I_RDMC) mask_q    <= rdata[FLAG_W-1:0];
      if (state == I_CLR) begin
        if (none) begin
          if (spurious_count != 8'hff) spurious_count <= spurious_count + 8'd1;
        end else begin
          isr_vector <= win_vector;
          if (irq_count != 16'hffff) irq_count <= irq_count + 16'd1;
        end
      end
      // Nested IRQs are masked while a vector is being serviced
      status_reg_interrupt_enable <= (nxt == I_ISR || nxt == I_EXEC) ? 1'b0 : sreg_i;
    end
  end

endmodule

// File: tb/tb_tc_host.sv
// Bench for tc_host: a tc register-file model answers the bus, commands and
// interrupts are randomized, and every observed cycle is compared against
// expectations derived from the register-level behaviour of the host.
module tb_tc_host;
  import tc_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        sreg_i = 1'b1;
  logic        isr_valid;
  logic [1:0]  isr_vector;
  logic        isr_done = 1'b0;
  logic        write, read;
  logic [7:0]  addr, wdata, rdata;
  logic        interrupt_request = 1'b0, interrupt_executed;
  logic        status_reg_interrupt_enable;
  logic [15:0] irq_count;
  logic [7:0]  spurious_count;

  // bench-side preload of the tc flag/mask registers
  logic        set_req = 1'b0;
  logic [7:0]  set_tifr = 8'h00, set_timsk = 8'h00;

  logic [7:0]  tc_regs  [256];
  logic [7:0]  exp_regs [256];
  int unsigned n_vec = 0, n_bad = 0;
  int unsigned exp_irq = 0, exp_spur = 0;
  logic [7:0]  cmd_addrs [6] = '{ADDR_TCCRA, ADDR_TCCRB, ADDR_TCNT, ADDR_OCRA, ADDR_OCRB, ADDR_TIMSK};

  always #5 clk = ~clk;

  tc_host dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sreg_i(sreg_i), .isr_valid(isr_valid), .isr_vector(isr_vector), .isr_done(isr_done),
    .write(write), .read(read), .addr(addr), .wdata(wdata), .rdata(rdata),
    .interrupt_request(interrupt_request), .interrupt_executed(interrupt_executed),
    .status_reg_interrupt_enable(status_reg_interrupt_enable),
    .irq_count(irq_count), .spurious_count(spurious_count)
  );

  // tc register file: one-edge read latency, TIFR is write-1-to-clear
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tc_regs[i] <= 8'h00;
      rdata <= 8'h00;
    end else begin
      if (set_req) begin
        tc_regs[ADDR_TIFR]  <= set_tifr;
        tc_regs[ADDR_TIMSK] <= set_timsk;
      end else if (write) begin
        if (addr == ADDR_TIFR) tc_regs[addr] <= tc_regs[addr] & ~wdata;
        else                   tc_regs[addr] <= wdata;
      end
      if (read) rdata <= tc_regs[addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_regs[i] = 8'h00;
    exp_irq  = 0;
    exp_spur = 0;
  endtask

  // Bus cycles that follow an accepted command
  task automatic finish_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    drive_edge();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 8'($urandom_range(0, 255));
    cmd_wdata = 8'($urandom_range(0, 255));
    sample_edge();
    if (w) begin
      check("wr_strobe", {write, read}, 2'b10);
      check("wr_addr", addr, a);
      check("wr_data", wdata, d);
      check("wr_ready", cmd_ready, 0);
      exp_regs[a] = d;
      drive_edge();
      sample_edge();
      check("wr_end", {write, read, addr, wdata}, 0);
      check("wr_no_rsp", rsp_valid, 0);
    end else begin
      check("rd1_strobe", {write, read}, 2'b01);
      check("rd1_addr", addr, a);
      check("rd1_ready", cmd_ready, 0);
      drive_edge();
      sample_edge();
      check("rd2_strobe", {write, read}, 2'b01);
      check("rd2_addr", addr, a);
      check("rd2_no_rsp", rsp_valid, 0);
      drive_edge();
      sample_edge();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_rdata", rsp_rdata, exp_regs[a]);
      check("rd_end", {write, read, addr}, 0);
      drive_edge();
      sample_edge();
      check("rsp_pulse", rsp_valid, 0);
    end
  endtask

  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    drive_edge();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    sample_edge();
    check("cmd_ready", cmd_ready, 1);
    check("cmd_idle_bus", {write, read, addr, wdata}, 0);
    finish_cmd(w, a, d);
  endtask

  // One interrupt service; optionally a command collides with the request
  task automatic service(input logic [2:0] flags, input logic [2:0] mask,
                         input int isr_wait, input int req_hold, input bit coll,
                         input logic cw, input logic [7:0] ca, input logic [7:0] cd);
    int          order [3] = '{OCFA_BIT, OCFB_BIT, TOV_BIT};
    logic [2:0]  pend;
    logic [7:0]  clr;
    logic [1:0]  evec;
    bit          found;
    pend  = flags & mask;
    found = 1'b0;
    clr   = 8'h00;
    evec  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && pend[order[k]]) begin
        found = 1'b1;
        clr   = 8'(1 << order[k]);
        evec  = 2'(k + 1);
      end
    end
    drive_edge();
    set_req   = 1'b1;
    set_tifr  = {5'b0, flags};
    set_timsk = {5'b0, mask};
    exp_regs[ADDR_TIMSK] = {5'b0, mask};
    sample_edge();
    check("pre_irq_sreie", status_reg_interrupt_enable, 1);
    drive_edge();
    set_req = 1'b0;
    interrupt_request = 1'b1;
    if (coll) begin
      cmd_valid = 1'b1;
      cmd_write = cw;
      cmd_addr  = ca;
      cmd_wdata = cd;
    end
    sample_edge();
    check("irq_prio_ready", cmd_ready, 0);
    check("irq_take_bus", {write, read}, 0);
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      isr_done = 1'($urandom_range(0, 1));
      sample_edge();
      check("irq_rd_strobe", {write, read}, 2'b01);
      check("irq_rd_addr", addr, (i < 2) ? ADDR_TIFR : ADDR_TIMSK);
      check("irq_rd_ready", cmd_ready, 0);
    end
    drive_edge();
    isr_done = 1'b0;
    sample_edge();
    if (found) begin
      check("clr_strobe", {write, read}, 2'b10);
      check("clr_addr", addr, ADDR_TIFR);
      check("clr_data", wdata, clr);
      drive_edge();
      sample_edge();
      exp_irq++;
      check("isr_valid", isr_valid, 1);
      check("isr_vector", isr_vector, evec);
      check("isr_sreie", status_reg_interrupt_enable, 0);
      check("irq_count", irq_count, exp_irq);
      check("isr_ready", cmd_ready, 0);
      for (int i = 0; i < isr_wait; i++) begin
        drive_edge();
        sample_edge();
        check("isr_pulse", isr_valid, 0);
        check("isr_wait_sreie", status_reg_interrupt_enable, 0);
        check("isr_wait_exec", interrupt_executed, 0);
        check("isr_wait_ready", cmd_ready, 0);
      end
      drive_edge();
      isr_done = 1'b1;
      sample_edge();
      check("isr_done_exec", interrupt_executed, 0);
      drive_edge();
      isr_done = 1'b0;
      sample_edge();
      check("exec_set", interrupt_executed, 1);
      check("exec_sreie", status_reg_interrupt_enable, 0);
    end else begin
      check("spur_no_write", {write, read, addr}, 0);
      drive_edge();
      sample_edge();
      exp_spur++;
      check("spur_exec", interrupt_executed, 1);
      check("spur_no_isr", isr_valid, 0);
      check("spur_count", spurious_count, exp_spur);
    end
    for (int i = 0; i < req_hold; i++) begin
      drive_edge();
      sample_edge();
      check("exec_hold", interrupt_executed, 1);
      check("exec_ready", cmd_ready, 0);
    end
    drive_edge();
    interrupt_request = 1'b0;
    sample_edge();
    check("exec_until_sampled", interrupt_executed, 1);
    drive_edge();
    sample_edge();
    check("exec_clear", interrupt_executed, 0);
    check("exit_sreie", status_reg_interrupt_enable, sreg_i);
    check("exit_ready", cmd_ready, coll);
    if (coll) finish_cmd(cw, ca, cd);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    clear_exp();
    repeat (3) @(posedge clk);
    sample_edge();
    check("rst_bus", {write, read, addr, wdata}, 0);
    check("rst_misc", {cmd_ready, rsp_valid, rsp_rdata, isr_valid, isr_vector, interrupt_executed}, 0);
    check("rst_sreie", status_reg_interrupt_enable, 0);
    check("rst_counts", {irq_count, spurious_count}, 0);
    drive_edge();
    rst = 1'b0;
    drive_edge();
    sample_edge();
    check("sreie_follow", status_reg_interrupt_enable, 1);

    // Directed: write then read back
    do_cmd(1'b1, ADDR_TCCRA, 8'h02);
    do_cmd(1'b0, ADDR_TCCRA, 8'h00);

    // Directed interrupt cases: OCFA win, mask filtering, spurious, collision
    service(3'b111, 3'b111, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    service(3'b101, 3'b100, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    service(3'b011, 3'b100, 0, 2, 1'b0, 1'b0, 8'h00, 8'h00);
    service(3'b001, 3'b111, 1, 0, 1'b1, 1'b1, ADDR_OCRB, 8'h5a);
    do_cmd(1'b0, ADDR_OCRB, 8'h00);

    // sreg_i low gates new entries while commands keep flowing
    drive_edge();
    sreg_i = 1'b0;
    drive_edge();
    sample_edge();
    check("gate_sreie", status_reg_interrupt_enable, 0);
    drive_edge();
    interrupt_request = 1'b1;
    sample_edge();
    check("gate_no_entry", {write, read}, 0);
    do_cmd(1'b1, ADDR_TCNT, 8'h33);
    do_cmd(1'b0, ADDR_TCNT, 8'h00);
    drive_edge();
    sample_edge();
    check("gate_still_idle", {write, read, interrupt_executed}, 0);
    drive_edge();
    interrupt_request = 1'b0;
    sreg_i = 1'b1;
    drive_edge();
    sample_edge();
    check("gate_release", status_reg_interrupt_enable, 1);

    // Randomized commands and interrupts
    for (int n = 0; n < 20; n++) begin
      do_cmd(1'($urandom_range(0, 1)), cmd_addrs[$urandom_range(0, 5)], 8'($urandom_range(0, 255)));
    end
    for (int n = 0; n < 12; n++) begin
      service(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), cmd_addrs[$urandom_range(0, 4)], 8'($urandom_range(0, 255)));
    end

    // Async reset in the capture cycle of a read
    drive_edge();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_OCRA;
    sample_edge();
    check("rstrd_ready", cmd_ready, 1);
    drive_edge();
    cmd_valid = 1'b0;
    sample_edge();
    check("rstrd_c_rd", read, 1);
    @(posedge clk);
    #2;
    check("rstrd_c_rdc", read, 1);
    rst = 1'b1;
    #1;
    check("rst_async_bus", {write, read, addr}, 0);
    clear_exp();
    for (int i = 0; i < 2; i++) begin
      sample_edge();
      check("rst_no_rsp", rsp_valid, 0);
      check("rst_mid_counts", {irq_count, spurious_count}, 0);
      check("rst_mid_misc", {status_reg_interrupt_enable, interrupt_executed, isr_valid, rsp_rdata}, 0);
    end
    drive_edge();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_edge();
      check("post_rst_no_rsp", rsp_valid, 0);
      drive_edge();
    end
    do_cmd(1'b1, ADDR_OCRA, 8'hc3);
    do_cmd(1'b0, ADDR_OCRA, 8'h00);
    service(3'b110, 3'b010, 0, 1, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
